// File: rtl/pkt_stream_gen.sv
// Packet stream source: accepts (len, gap) requests and emits sop/vld/eop framed beats with a sequence-tagged payload.
// Optional statistics counters are enabled with `define PKT_STREAM_GEN_STATS_EN.
module pkt_stream_gen #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 8,
  parameter int GAP_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req_vld,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [GAP_W-1:0]  req_gap,
  output logic              req_rdy,
  input  logic              out_rdy,
  output logic              sop,
  output logic              vld,
  output logic              eop,
  output logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  seq,
  output logic              busy,
  output logic              err_len
`ifdef PKT_STREAM_GEN_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_pkts,
  output logic [CNT_W-1:0]  stat_beats,
  output logic [CNT_W-1:0]  stat_stall
`endif
);

  // state | meaning
  // IDLE  | waiting for a request; req_rdy follows en
  // SEND  | emitting beats, held stable while out_rdy is low
  // GAP   | idle down-count of the latched gap after eop
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   seq_q, seq_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               sop_q, sop_d;
  logic               vld_q, vld_d;
  logic               eop_q, eop_d;
  logic               err_len_q, err_len_d;

  logic               accept;
  logic               xfer;
  logic [LEN_W-1:0]   beat_nxt;
  logic [DATA_W-1:0]  seq_ext;

  assign req_rdy  = rst_n && en && (state_q == S_IDLE);
  assign accept   = req_vld && req_rdy;
  assign xfer     = vld_q && out_rdy;
  assign beat_nxt = beat_q + 1'b1;
  assign seq_ext  = DATA_W'(seq_q);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    seq_d     = seq_q;
    data_d    = data_q;
    sop_d     = sop_q;
    vld_d     = vld_q;
    eop_d     = eop_q;
    err_len_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_len == '0) begin
            err_len_d = 1'b1;
          end else begin
            state_d = S_SEND;
            len_d   = req_len;
            gap_d   = req_gap;
            beat_d  = '0;
            sop_d   = 1'b1;
            vld_d   = 1'b1;
            eop_d   = (req_len == LEN_W'(1));
            data_d  = seq_ext;
          end
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (eop_q) begin
            seq_d   = seq_q + 1'b1;
            sop_d   = 1'b0;
            vld_d   = 1'b0;
            eop_d   = 1'b0;
            state_d = (gap_q != '0) ? S_GAP : S_IDLE;
          end else begin
            beat_d = beat_nxt;
            sop_d  = 1'b0;
            eop_d  = (beat_nxt == len_q - 1'b1);
            data_d = seq_ext + DATA_W'(beat_nxt);
          end
        end
      end
      S_GAP: begin
        // gap_q doubles as the down-counter; terminal count at 1
        gap_d = gap_q - 1'b1;
        if (gap_q == GAP_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      seq_q     <= '0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      vld_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      seq_q     <= seq_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      vld_q     <= vld_d;
      eop_q     <= eop_d;
      err_len_q <= err_len_d;
    end
  end

  assign sop     = sop_q;
  assign vld     = vld_q;
  assign eop     = eop_q;
  assign len     = len_q;
  assign data    = data_q;
  assign seq     = seq_q;
  assign busy    = (state_q != S_IDLE);
  assign err_len = err_len_q;

`ifdef PKT_STREAM_GEN_STATS_EN
  logic [CNT_W-1:0] stat_pkts_q, stat_pkts_d;
  logic [CNT_W-1:0] stat_beats_q, stat_beats_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  // counters saturate at all-ones rather than wrapping
  always_comb begin
    stat_pkts_d  = stat_pkts_q;
    stat_beats_d = stat_beats_q;
    stat_stall_d = stat_stall_q;
    if (xfer && eop_q && (stat_pkts_q != '1)) stat_pkts_d = stat_pkts_q + 1'b1;
    if (xfer && (stat_beats_q != '1))         stat_beats_d = stat_beats_q + 1'b1;
    if (vld_q && !out_rdy && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pkts_q  <= '0;
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_beats_q <= stat_beats_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_beats = stat_beats_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_pkt_stream_gen.sv
// Randomized bench for pkt_stream_gen against a packet-level reference model (expected beat list, seq and gap timing).
module tb_pkt_stream_gen;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 8;
  localparam int GAP_W  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n, en, req_vld, out_rdy;
  logic [LEN_W-1:0]  req_len;
  logic [GAP_W-1:0]  req_gap;
  logic              req_rdy, sop, vld, eop, busy, err_len;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  seq;
`ifdef PKT_STREAM_GEN_STATS_EN
  logic [CNT_W-1:0]  stat_pkts, stat_beats, stat_stall;
`endif

  pkt_stream_gen #(.LEN_W(LEN_W), .DATA_W(DATA_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_vld(req_vld), .req_len(req_len),
    .req_gap(req_gap), .req_rdy(req_rdy), .out_rdy(out_rdy), .sop(sop), .vld(vld),
    .eop(eop), .len(len), .data(data), .seq(seq), .busy(busy), .err_len(err_len)
`ifdef PKT_STREAM_GEN_STATS_EN
    , .stat_pkts(stat_pkts), .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_seq, m_pkts, m_beats, m_stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_seq = 0; m_pkts = 0; m_beats = 0; m_stalls = 0;
  endtask

  task automatic chk_stats();
`ifdef PKT_STREAM_GEN_STATS_EN
    chk("stat_pkts", 32'(stat_pkts), m_pkts);
    chk("stat_beats", 32'(stat_beats), m_beats);
    chk("stat_stall", 32'(stat_stall), m_stalls);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sop"}, 32'(sop), 0);
    chk({tag, "_vld"}, 32'(vld), 0);
    chk({tag, "_eop"}, 32'(eop), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err_len), 0);
    chk({tag, "_len"}, 32'(len), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_seq"}, 32'(seq), 0);
    chk({tag, "_rdy"}, 32'(req_rdy), 0);
    chk_stats();
  endtask

  task automatic wait_accept(input int plen, input int pgap);
    int waitc;
    req_vld = 1'b1;
    req_len = LEN_W'(plen);
    req_gap = GAP_W'(pgap);
    en = 1'b1;
    #1;
    waitc = 0;
    while (!req_rdy && waitc < 50) begin
      step();
      waitc++;
    end
    chk("req_rdy_wait", 32'(req_rdy), 1);
    step();
    req_vld = 1'b0;
  endtask

  // One request; the expected beats come from len/seq alone.
  task automatic send_pkt(input int plen, input int pgap, input int stall_beat,
                          input int stall_n, input bit rnd);
    int b, stalls, guard;
    wait_accept(plen, pgap);
    if (plen == 0) begin
      chk("zl_err", 32'(err_len), 1);
      chk("zl_vld", 32'(vld), 0);
      chk("zl_seq", 32'(seq), exp_seq);
      chk("zl_rdy", 32'(req_rdy), 1);
      step();
      chk("zl_err_pulse", 32'(err_len), 0);
      chk("zl_vld2", 32'(vld), 0);
      return;
    end
    b = 0; stalls = 0; guard = 0;
    while (b < plen && guard < 300) begin
      guard++;
      chk("vld", 32'(vld), 1);
      chk("sop", 32'(sop), (b == 0));
      chk("eop", 32'(eop), (b == plen - 1));
      chk("data", 32'(data), (exp_seq + b) % 256);
      chk("len", 32'(len), plen);
      chk("seq", 32'(seq), exp_seq);
      chk("busy", 32'(busy), 1);
      chk("rdy_in_send", 32'(req_rdy), 0);
      if (rnd) begin
        out_rdy = ($urandom_range(0, 2) != 0) || (guard > 200);
        en      = 1'($urandom_range(0, 1));
      end else begin
        out_rdy = !(b == stall_beat && stalls < stall_n);
      end
      if (!out_rdy) begin
        stalls++;
        m_stalls++;
      end else begin
        b++;
        m_beats++;
      end
      if (b == plen) en = 1'b1;
      step();
    end
    chk("xfer_count", b, plen);
    m_pkts++;
    exp_seq = (exp_seq + 1) % 65536;
    out_rdy = 1'b1;
    chk("post_vld", 32'(vld), 0);
    chk("post_seq", 32'(seq), exp_seq);
    for (int i = 0; i < pgap; i++) begin
      chk("gap_rdy", 32'(req_rdy), 0);
      chk("gap_vld", 32'(vld), 0);
      chk("gap_busy", 32'(busy), 1);
      step();
    end
    chk("post_gap_rdy", 32'(req_rdy), 1);
    chk("post_gap_busy", 32'(busy), 0);
    chk_stats();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req_vld = 1'b0; out_rdy = 1'b1;
    req_len = '0; req_gap = '0;
    step();
    step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    model_clear();
    step();

    send_pkt(3, 0, -1, 0, 1'b0);
    send_pkt(1, 0, -1, 0, 1'b0);
    send_pkt(4, 0, 2, 3, 1'b0);
`ifdef PKT_STREAM_GEN_STATS_EN
    chk("stall_three", 32'(stat_stall), 3);
`endif
    send_pkt(0, 0, -1, 0, 1'b0);
    send_pkt(2, 5, -1, 0, 1'b0);
    send_pkt(2, 0, -1, 0, 1'b0);
    send_pkt(15, 1, -1, 0, 1'b0);

    // abort in the middle of a 5-beat packet
    wait_accept(5, 0);
    out_rdy = 1'b1;
    step();
    step();
    chk("mid_data", 32'(data), (exp_seq + 2) % 256);
    chk("mid_sop", 32'(sop), 0);
    rst_n = 1'b0;
    step();
    chk_all_zero("abort");
    rst_n = 1'b1;
    model_clear();
    step();
    en = 1'b0;
    req_vld = 1'b1;
    req_len = LEN_W'(3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("en_low_rdy", 32'(req_rdy), 0);
      chk("en_low_vld", 32'(vld), 0);
      step();
    end
    req_vld = 1'b0;
    en = 1'b1;
    chk("en_low_seq", 32'(seq), 0);

    for (int k = 0; k < 40; k++) begin
      send_pkt(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)), -1, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
